mlsu_axi_mem_responder: RTL and testbench



---
 rtl/mlsu_axi_mem_responder.sv | 240 ++++++++++++++++++++++++
 tb/tb_mlsu_axi_mem_responder.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlsu_axi_mem_responder.sv
// AXI4 subordinate backed by a byte-strobed flop memory.
// One read and one write burst in flight; channels independent.
module mlsu_axi_mem_responder #(
  parameter int AxiDataWidth = 64,
  parameter int AxiAddrWidth = 32,
  parameter int AxiIdWidth   = 4,
  parameter int MemBytes     = 4096,
  parameter int ReadLatency  = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      aw_valid_i,
  output logic                      aw_ready_o,
  input  logic [AxiIdWidth-1:0]     aw_id_i,
  input  logic [AxiAddrWidth-1:0]   aw_addr_i,
  input  logic [7:0]                aw_len_i,
  input  logic [2:0]                aw_size_i,
  input  logic [1:0]                aw_burst_i,
  input  logic                      w_valid_i,
  output logic                      w_ready_o,
  input  logic [AxiDataWidth-1:0]   w_data_i,
  input  logic [AxiDataWidth/8-1:0] w_strb_i,
  input  logic                      w_last_i,
  output logic                      b_valid_o,
  input  logic                      b_ready_i,
  output logic [AxiIdWidth-1:0]     b_id_o,
  output logic [1:0]                b_resp_o,
  input  logic                      ar_valid_i,
  output logic                      ar_ready_o,
  input  logic [AxiIdWidth-1:0]     ar_id_i,
  input  logic [AxiAddrWidth-1:0]   ar_addr_i,
  input  logic [7:0]                ar_len_i,
  input  logic [2:0]                ar_size_i,
  input  logic [1:0]                ar_burst_i,
  output logic                      r_valid_o,
  input  logic                      r_ready_i,
  output logic [AxiIdWidth-1:0]     r_id_o,
  output logic [AxiDataWidth-1:0]   r_data_o,
  output logic [1:0]                r_resp_o,
  output logic                      r_last_o
);

  localparam int StrbW = AxiDataWidth / 8;
  localparam int OffW  = $clog2(StrbW);
  localparam int Words = MemBytes / StrbW;
  localparam int IdxW  = $clog2(Words);
  localparam int MemAw = $clog2(MemBytes);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  logic [AxiDataWidth-1:0] mem [Words];

  function automatic logic [1:0] chk(
    input logic [AxiAddrWidth-1:0] a,
    input logic [2:0]              size,
    input logic [1:0]              burst
  );
    if (burst[1] || (int'(size) > OffW)) chk = SLVERR;
    else if (|a[AxiAddrWidth-1:MemAw])  chk = DECERR;
    else                                chk = OKAY;
  endfunction

  function automatic logic [AxiAddrWidth-1:0] align(
    input logic [AxiAddrWidth-1:0] a,
    input logic [2:0]              size
  );
    align = a & ({AxiAddrWidth{1'b1}} << size);
  endfunction

  function automatic logic [AxiAddrWidth-1:0] nxt(
    input logic [AxiAddrWidth-1:0] a,
    input logic [2:0]              size,
    input logic [1:0]              burst
  );
    nxt = (burst == 2'b01) ? a + (AxiAddrWidth'(1) << size) : a;
  endfunction

  function automatic logic [IdxW-1:0] idx(input logic [AxiAddrWidth-1:0] a);
    idx = a[MemAw-1:OffW];
  endfunction

  // Write channel
  logic [1:0]              w_state;
  logic [AxiIdWidth-1:0]   w_id;
  logic [AxiAddrWidth-1:0] w_addr;
  logic [2:0]              w_size;
  logic [1:0]              w_burst;
  logic [7:0]              w_len;
  logic [8:0]              w_cnt;
  logic [1:0]              w_err;
  logic                    aw_hs, w_hs, b_hs;

  assign aw_ready_o = (w_state == W_IDLE) && !rst_i;
  assign w_ready_o  = (w_state == W_DATA) && !rst_i;
  assign aw_hs      = aw_valid_i && aw_ready_o;
  assign w_hs       = w_valid_i && w_ready_o;
  assign b_hs       = b_valid_o && b_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state   <= W_IDLE;
      w_id      <= '0;
      w_addr    <= '0;
      w_size    <= '0;
      w_burst   <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      w_err     <= OKAY;
      b_valid_o <= 1'b0;
      b_id_o    <= '0;
      b_resp_o  <= OKAY;
    end else begin
      case (w_state)
        W_IDLE: if (aw_hs) begin
          w_id    <= aw_id_i;
          w_addr  <= align(aw_addr_i, aw_size_i);
          w_size  <= aw_size_i;
          w_burst <= aw_burst_i;
          w_len   <= aw_len_i;
          w_cnt   <= '0;
          w_err   <= chk(aw_addr_i, aw_size_i, aw_burst_i);
          w_state <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          w_addr <= nxt(w_addr, w_size, w_burst);
          w_cnt  <= w_cnt + 9'd1;
          if (w_last_i) begin
            w_state   <= W_RESP;
            b_valid_o <= 1'b1;
            b_id_o    <= w_id;
            if (w_err != OKAY)            b_resp_o <= w_err;
            else if (w_cnt != {1'b0, w_len}) b_resp_o <= SLVERR;
            else                          b_resp_o <= OKAY;
          end
        end
        W_RESP: if (b_hs) begin
          b_valid_o <= 1'b0;
          w_state   <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Memory has no reset; erroring bursts never write
  always_ff @(posedge clk_i) begin
    if (w_hs && (w_err == OKAY)) begin
      for (int b = 0; b < StrbW; b++) begin
        if (w_strb_i[b]) mem[idx(w_addr)][8*b +: 8] <= w_data_i[8*b +: 8];
      end
    end
  end

  // Read channel
  logic [1:0]              r_state;
  logic [AxiIdWidth-1:0]   r_id;
  logic [AxiAddrWidth-1:0] r_addr;
  logic [2:0]              r_size;
  logic [1:0]              r_burst;
  logic [7:0]              r_len;
  logic [7:0]              r_beat;
  logic [1:0]              r_err;
  logic [3:0]              r_lat;
  logic                    ar_hs, r_hs;
  logic [AxiDataWidth-1:0] rd_word;

  assign ar_ready_o = (r_state == R_IDLE) && !rst_i;
  assign ar_hs      = ar_valid_i && ar_ready_o;
  assign r_hs       = r_valid_o && r_ready_i;
  assign rd_word    = (r_err == OKAY) ? mem[idx(r_addr)] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= R_IDLE;
      r_id      <= '0;
      r_addr    <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_err     <= OKAY;
      r_lat     <= '0;
      r_valid_o <= 1'b0;
      r_id_o    <= '0;
      r_data_o  <= '0;
      r_resp_o  <= OKAY;
      r_last_o  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (ar_hs) begin
          r_id    <= ar_id_i;
          r_addr  <= align(ar_addr_i, ar_size_i);
          r_size  <= ar_size_i;
          r_burst <= ar_burst_i;
          r_len   <= ar_len_i;
          r_err   <= chk(ar_addr_i, ar_size_i, ar_burst_i);
          r_lat   <= 4'(ReadLatency - 1);
          r_state <= R_WAIT;
        end
        R_WAIT: begin
          if (r_lat == 4'd0) begin
            r_state   <= R_DATA;
            r_valid_o <= 1'b1;
            r_id_o    <= r_id;
            r_resp_o  <= r_err;
            r_data_o  <= rd_word;
            r_last_o  <= (r_len == 8'd0);
            r_beat    <= 8'd0;
            r_addr    <= nxt(r_addr, r_size, r_burst);
          end else begin
            r_lat <= r_lat - 4'd1;
          end
        end
        R_DATA: if (r_hs) begin
          if (r_last_o) begin
            r_valid_o <= 1'b0;
            r_last_o  <= 1'b0;
            r_state   <= R_IDLE;
          end else begin
            r_data_o <= rd_word;
            r_last_o <= ((r_beat + 8'd1) == r_len);
            r_beat   <= r_beat + 8'd1;
            r_addr   <= nxt(r_addr, r_size, r_burst);
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlsu_axi_mem_responder.sv
// Directed self-checking bench for mlsu_axi_mem_responder.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_mlsu_axi_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        aw_valid, aw_ready;
  logic [3:0]  aw_id;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic        w_valid, w_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last;
  logic        b_valid, b_ready;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic        ar_valid, ar_ready;
  logic [3:0]  ar_id;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_valid, r_ready;
  logic [3:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;

  int ncmp = 0;
  int nerr = 0;

  logic [63:0] rd_data [32];
  logic        rd_last [32];
  logic [1:0]  rd_resp [32];
  logic [3:0]  rd_id   [32];
  int rd_cnt, first_c, stable_err, nstall;
  logic [3:0] bid;
  logic [1:0] bresp;

  always #5 clk = ~clk;

  mlsu_axi_mem_responder dut (
    .clk_i(clk), .rst_i(rst),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
    .aw_id_i(aw_id), .aw_addr_i(aw_addr), .aw_len_i(aw_len),
    .aw_size_i(aw_size), .aw_burst_i(aw_burst),
    .w_valid_i(w_valid), .w_ready_o(w_ready),
    .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last),
    .b_valid_o(b_valid), .b_ready_i(b_ready),
    .b_id_o(b_id), .b_resp_o(b_resp),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
    .ar_id_i(ar_id), .ar_addr_i(ar_addr), .ar_len_i(ar_len),
    .ar_size_i(ar_size), .ar_burst_i(ar_burst),
    .r_valid_o(r_valid), .r_ready_i(r_ready),
    .r_id_o(r_id), .r_data_o(r_data), .r_resp_o(r_resp),
    .r_last_o(r_last)
  );

  task automatic aw_send(input logic [3:0] id, input logic [31:0] a,
                         input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bu);
    int n = 0;
    bit hs = 0;
    aw_id = id; aw_addr = a; aw_len = len; aw_size = sz; aw_burst = bu;
    aw_valid = 1'b1;
    while (!hs && n < 20) begin
      @(negedge clk); hs = aw_ready;
      @(posedge clk); #1; n++;
    end
    aw_valid = 1'b0;
    ncmp++;
    if (!hs) begin
      nerr++;
      $display("FAIL aw_hs: aw_ready stayed 0, required 1 within 20 cycles");
    end
  endtask

  task automatic w_send(input logic [63:0] d, input logic [7:0] s,
                        input logic l);
    int n = 0;
    bit hs = 0;
    w_data = d; w_strb = s; w_last = l; w_valid = 1'b1;
    while (!hs && n < 20) begin
      @(negedge clk); hs = w_ready;
      @(posedge clk); #1; n++;
    end
    w_valid = 1'b0; w_last = 1'b0;
    ncmp++;
    if (!hs) begin
      nerr++;
      $display("FAIL w_hs: w_ready stayed 0, required 1 within 20 cycles");
    end
  endtask

  task automatic b_recv(output logic [3:0] id, output logic [1:0] rs);
    int n = 0;
    bit hs = 0;
    id = 'x; rs = 'x;
    b_ready = 1'b1;
    while (!hs && n < 20) begin
      @(negedge clk);
      if (b_valid) begin hs = 1; id = b_id; rs = b_resp; end
      @(posedge clk); #1; n++;
    end
    b_ready = 1'b0;
    ncmp++;
    if (!hs) begin
      nerr++;
      $display("FAIL b_hs: b_valid stayed 0, required 1 within 20 cycles");
    end
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] a,
                         input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bu);
    int n = 0;
    bit hs = 0;
    ar_id = id; ar_addr = a; ar_len = len; ar_size = sz; ar_burst = bu;
    ar_valid = 1'b1;
    while (!hs && n < 20) begin
      @(negedge clk); hs = ar_ready;
      @(posedge clk); #1; n++;
    end
    ar_valid = 1'b0;
    ncmp++;
    if (!hs) begin
      nerr++;
      $display("FAIL ar_hs: ar_ready stayed 0, required 1 within 20 cycles");
    end
  endtask

  // Called right after an AR handshake; c counts cycles from that edge.
  task automatic collect_r(input int nb, input bit toggle);
    int c = 0;
    bit have_prev = 0;
    logic [63:0] pd;
    logic pl;
    rd_cnt = 0; first_c = -1; stable_err = 0; nstall = 0;
    while (rd_cnt < nb && c < 200) begin
      r_ready = toggle ? (c % 3 == 0) : 1'b1;
      @(negedge clk);
      if (r_valid) begin
        if (first_c < 0) first_c = c;
        if (have_prev && (r_data !== pd || r_last !== pl)) stable_err++;
        if (r_ready) begin
          rd_data[rd_cnt] = r_data; rd_last[rd_cnt] = r_last;
          rd_resp[rd_cnt] = r_resp; rd_id[rd_cnt] = r_id;
          rd_cnt++; have_prev = 0;
        end else begin
          nstall++; have_prev = 1; pd = r_data; pl = r_last;
        end
      end
      @(posedge clk); #1; c++;
    end
    r_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    ncmp++;
    if (aw_ready !== 1'b0 || ar_ready !== 1'b0 || w_ready !== 1'b0) begin
      nerr++;
      $display("FAIL rst_ready: aw/ar/w=%b%b%b required 000", aw_ready, ar_ready, w_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ncmp++;
    if (aw_ready !== 1'b1 || ar_ready !== 1'b1) begin
      nerr++;
      $display("FAIL post_rst_ready: aw=%b ar=%b required 1 1", aw_ready, ar_ready);
    end
    ncmp++;
    if (b_valid !== 1'b0 || r_valid !== 1'b0 || w_ready !== 1'b0) begin
      nerr++;
      $display("FAIL post_rst_valid: b=%b r=%b w_ready=%b required 0", b_valid, r_valid, w_ready);
    end
    ncmp++;
    if (r_data !== 64'h0 || b_resp !== 2'b00 || r_last !== 1'b0) begin
      nerr++;
      $display("FAIL post_rst_payload: r_data=%h b_resp=%b r_last=%b required 0", r_data, b_resp, r_last);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_incr_burst;
    aw_send(4'd5, 32'h40, 8'd3, 3'd3, 2'b01);
    for (int i = 0; i < 4; i++) w_send(64'h11 * (i + 1), 8'hFF, i == 3);
    b_recv(bid, bresp);
    ncmp++;
    if (bid !== 4'd5 || bresp !== 2'b00) begin
      nerr++;
      $display("FAIL incr_b: id=%0d resp=%b required 5 00", bid, bresp);
    end
    ar_send(4'd5, 32'h40, 8'd3, 3'd3, 2'b01);
    collect_r(4, 1'b0);
    ncmp++;
    if (first_c != 2) begin
      nerr++;
      $display("FAIL incr_latency: first r_valid at %0d required 2", first_c);
    end
    ncmp++;
    if (rd_cnt != 4) begin
      nerr++;
      $display("FAIL incr_beats: got %0d required 4", rd_cnt);
    end
    for (int i = 0; i < rd_cnt; i++) begin
      ncmp++;
      if (rd_data[i] !== 64'h11 * (i + 1) || rd_last[i] !== (i == 3) ||
          rd_resp[i] !== 2'b00 || rd_id[i] !== 4'd5) begin
        nerr++;
        $display("FAIL incr_r%0d: data=%h last=%b resp=%b id=%0d required %h %b 00 5",
                 i, rd_data[i], rd_last[i], rd_resp[i], rd_id[i], 64'h11 * (i + 1), i == 3);
      end
    end
  endtask

  task automatic test_strobe;
    aw_send(4'd1, 32'h0, 8'd0, 3'd3, 2'b01);
    w_send(64'hFFFFFFFF_FFFFFFFF, 8'hFF, 1'b1);
    b_recv(bid, bresp);
    aw_send(4'd1, 32'h0, 8'd0, 3'd3, 2'b01);
    w_send(64'hAAAAAAAA_BBBBBBBB, 8'h0F, 1'b1);
    b_recv(bid, bresp);
    ncmp++;
    if (bresp !== 2'b00) begin
      nerr++;
      $display("FAIL strb_b: resp=%b required 00", bresp);
    end
    ar_send(4'd2, 32'h0, 8'd0, 3'd3, 2'b01);
    collect_r(1, 1'b0);
    ncmp++;
    if (rd_cnt != 1 || rd_data[0] !== 64'hFFFFFFFF_BBBBBBBB ||
        rd_last[0] !== 1'b1 || rd_id[0] !== 4'd2) begin
      nerr++;
      $display("FAIL strb_r: n=%0d data=%h last=%b id=%0d required 1 ffffffffbbbbbbbb 1 2",
               rd_cnt, rd_data[0], rd_last[0], rd_id[0]);
    end
  endtask

  task automatic test_stall;
    aw_send(4'd3, 32'h100, 8'd7, 3'd3, 2'b01);
    for (int i = 0; i < 8; i++) w_send(64'h01010101_01010101 * (i + 1), 8'hFF, i == 7);
    b_recv(bid, bresp);
    ncmp++;
    if (bresp !== 2'b00) begin
      nerr++;
      $display("FAIL stall_b: resp=%b required 00", bresp);
    end
    ar_send(4'd3, 32'h100, 8'd7, 3'd3, 2'b01);
    collect_r(8, 1'b1);
    ncmp++;
    if (rd_cnt != 8 || nstall == 0 || stable_err != 0) begin
      nerr++;
      $display("FAIL stall_hold: beats=%0d stalls=%0d unstable=%0d required 8 >0 0",
               rd_cnt, nstall, stable_err);
    end
    for (int i = 0; i < rd_cnt; i++) begin
      ncmp++;
      if (rd_data[i] !== 64'h01010101_01010101 * (i + 1) || rd_last[i] !== (i == 7)) begin
        nerr++;
        $display("FAIL stall_r%0d: data=%h last=%b required %h %b",
                 i, rd_data[i], rd_last[i], 64'h01010101_01010101 * (i + 1), i == 7);
      end
    end
  endtask

  task automatic test_errors;
    ar_send(4'd4, 32'h1000, 8'd1, 3'd3, 2'b01);
    collect_r(2, 1'b0);
    ncmp++;
    if (rd_cnt != 2) begin
      nerr++;
      $display("FAIL decerr_beats: got %0d required 2", rd_cnt);
    end
    for (int i = 0; i < rd_cnt; i++) begin
      ncmp++;
      if (rd_data[i] !== 64'h0 || rd_resp[i] !== 2'b11 || rd_last[i] !== (i == 1)) begin
        nerr++;
        $display("FAIL decerr_r%0d: data=%h resp=%b last=%b required 0 11 %b",
                 i, rd_data[i], rd_resp[i], rd_last[i], i == 1);
      end
    end
    aw_send(4'd6, 32'h0, 8'd0, 3'd3, 2'b10);
    w_send(64'h12345678_9ABCDEF0, 8'hFF, 1'b1);
    b_recv(bid, bresp);
    ncmp++;
    if (bid !== 4'd6 || bresp !== 2'b10) begin
      nerr++;
      $display("FAIL wrap_b: id=%0d resp=%b required 6 10", bid, bresp);
    end
    ar_send(4'd4, 32'h0, 8'd0, 3'd3, 2'b01);
    collect_r(1, 1'b0);
    ncmp++;
    if (rd_data[0] !== 64'hFFFFFFFF_BBBBBBBB || rd_resp[0] !== 2'b00) begin
      nerr++;
      $display("FAIL wrap_nowrite: data=%h resp=%b required ffffffffbbbbbbbb 00",
               rd_data[0], rd_resp[0]);
    end
  endtask

  task automatic test_short_burst;
    aw_send(4'd7, 32'h300, 8'd3, 3'd3, 2'b01);
    w_send(64'hD0D0D0D0_00000001, 8'hFF, 1'b0);
    w_send(64'hD1D1D1D1_00000002, 8'hFF, 1'b1);
    b_recv(bid, bresp);
    ncmp++;
    if (bid !== 4'd7 || bresp !== 2'b10) begin
      nerr++;
      $display("FAIL short_b: id=%0d resp=%b required 7 10", bid, bresp);
    end
    ar_send(4'd7, 32'h300, 8'd1, 3'd3, 2'b01);
    collect_r(2, 1'b0);
    ncmp++;
    if (rd_data[0] !== 64'hD0D0D0D0_00000001 || rd_data[1] !== 64'hD1D1D1D1_00000002) begin
      nerr++;
      $display("FAIL short_data: %h %h required d0d0d0d000000001 d1d1d1d100000002",
               rd_data[0], rd_data[1]);
    end
  endtask

  task automatic test_reset_mid_read;
    int n = 0;
    int c = 0;
    ar_send(4'd8, 32'h100, 8'd3, 3'd3, 2'b01);
    r_ready = 1'b1;
    while (n < 2 && c < 50) begin
      @(negedge clk);
      if (r_valid) n++;
      @(posedge clk); #1; c++;
    end
    ncmp++;
    if (n != 2 || r_valid !== 1'b1) begin
      nerr++;
      $display("FAIL mid_pre: beats=%0d r_valid=%b required 2 1", n, r_valid);
    end
    r_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ncmp++;
    if (r_valid !== 1'b0 || ar_ready !== 1'b0 || r_data !== 64'h0) begin
      nerr++;
      $display("FAIL mid_rst: r_valid=%b ar_ready=%b r_data=%h required 0 0 0",
               r_valid, ar_ready, r_data);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    ncmp++;
    if (ar_ready !== 1'b1 || r_valid !== 1'b0) begin
      nerr++;
      $display("FAIL mid_release: ar_ready=%b r_valid=%b required 1 0", ar_ready, r_valid);
    end
    n = 0;
    r_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (r_valid) n++;
    end
    r_ready = 1'b0;
    ncmp++;
    if (n != 0) begin
      nerr++;
      $display("FAIL mid_abandon: %0d stray beats required 0", n);
    end
    @(posedge clk); #1;
    ar_send(4'd9, 32'h100, 8'd0, 3'd3, 2'b01);
    collect_r(1, 1'b0);
    ncmp++;
    if (rd_data[0] !== 64'h01010101_01010101 || rd_id[0] !== 4'd9) begin
      nerr++;
      $display("FAIL mem_kept: data=%h id=%0d required 0101010101010101 9",
               rd_data[0], rd_id[0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
    w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
    ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
    r_ready = 0;
    test_reset();
    test_incr_burst();
    test_strobe();
    test_stall();
    test_errors();
    test_short_burst();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
